// File: rtl/fsm_bit_serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding and default word width.
// These were previously held in the fsm_defs.vh include.
package fsm_bit_serializer_pkg;

   // Serializer FSM states
   typedef enum logic {
      S_IDLE  = 1'b0,   // no active word
      S_SHIFT = 1'b1    // shift_reg holds a word being sent
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder for the Mealy sequence detectors.
// Accepts words over valid/ready and emits one bit per enabled clock on x.
// An active shift register plus one hold register give zero-gap streaming
// of back-to-back words.
module fsm_bit_serializer
   import fsm_bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enable,
   input  logic             flush,
   output logic             x,
   output logic             x_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] shift_reg, shift_nx;
   logic [WIDTH-1:0] hold_reg, hold_nx;
   logic             hold_full, hold_full_nx;
   logic [CW-1:0]    bitcnt, bitcnt_nx;
   logic [WIDTH-1:0] shifted;
   logic             accept;
   logic             advance;
   logic             last_bit;

   // Handshake and advance qualifiers
   always_comb begin
      in_ready = reset && !flush && !hold_full;
      accept   = in_valid && in_ready;
      advance  = (state == S_SHIFT) && enable;
      last_bit = advance && (bitcnt == LAST);
   end

   // Shift the active word one place toward the output end
   always_comb begin
      if (MSB_FIRST) begin
         shifted = {shift_reg[WIDTH-2:0], 1'b0};
      end else begin
         shifted = {1'b0, shift_reg[WIDTH-1:1]};
      end
   end

   // Next-state logic: flush first, then last-bit handoff, then advance/accept
   always_comb begin
      state_nx     = state;
      shift_nx     = shift_reg;
      hold_nx      = hold_reg;
      hold_full_nx = hold_full;
      bitcnt_nx    = bitcnt;
      if (flush) begin
         state_nx     = S_IDLE;
         hold_full_nx = 1'b0;
         bitcnt_nx    = '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  shift_nx  = in_data;
                  bitcnt_nx = '0;
                  state_nx  = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (last_bit) begin
                  // hold_full blocks in_ready, so accept and hold_full are exclusive here
                  bitcnt_nx = '0;
                  if (hold_full) begin
                     shift_nx     = hold_reg;
                     hold_full_nx = 1'b0;
                  end else if (accept) begin
                     shift_nx = in_data;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else begin
                  if (advance) begin
                     shift_nx  = shifted;
                     bitcnt_nx = bitcnt + 1'b1;
                  end
                  if (accept) begin
                     hold_nx      = in_data;
                     hold_full_nx = 1'b1;
                  end
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // State, data and counter registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         shift_reg <= '0;
         hold_reg  <= '0;
         hold_full <= 1'b0;
         bitcnt    <= '0;
      end else begin
         state     <= state_nx;
         shift_reg <= shift_nx;
         hold_reg  <= hold_nx;
         hold_full <= hold_full_nx;
         bitcnt    <= bitcnt_nx;
      end
   end

   // Output decode straight from the registers
   always_comb begin
      if (state == S_SHIFT) begin
         x = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
      end else begin
         x = IDLE_BIT;
      end
      x_valid     = (state == S_SHIFT) && enable;
      frame_start = x_valid && (bitcnt == '0);
      frame_end   = x_valid && (bitcnt == LAST);
      busy        = (state == S_SHIFT) || hold_full;
   end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Bench for fsm_bit_serializer: word-level queue model feeds an expected-bit
// scoreboard; a negedge monitor pops and compares every live bit.
module tb_fsm_bit_serializer;

   localparam int unsigned W = 8;

   typedef struct {
      logic b;
      logic s;
      logic e;
   } ent_t;

   logic         clk;
   logic         reset;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         enable;
   logic         flush;
   logic         x;
   logic         x_valid;
   logic         frame_start;
   logic         frame_end;
   logic         busy;

   int   errors = 0;
   int   checks = 0;
   ent_t expq[$];
   int   nwords = 0;   // words held by the model: active + pending
   int   bitpos = 0;   // bits of the head word already emitted

   fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .enable(enable), .flush(flush), .x(x),
      .x_valid(x_valid), .frame_start(frame_start), .frame_end(frame_end),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words are queued whole; each enabled cycle consumes one bit
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         nwords = 0;
         bitpos = 0;
         expq.delete();
      end else if (flush) begin
         nwords = 0;
         bitpos = 0;
         expq.delete();
      end else begin
         automatic bit acc = in_valid && (nwords < 2);
         if (nwords > 0 && enable) begin
            bitpos++;
            if (bitpos == W) begin
               nwords--;
               bitpos = 0;
            end
         end
         if (acc) begin
            nwords++;
            for (int i = 0; i < W; i++) begin
               automatic ent_t t;
               t.b = in_data[W-1-i];
               t.s = (i == 0);
               t.e = (i == W - 1);
               expq.push_back(t);
            end
         end
      end
   end

   // Monitor: compare handshake/status each cycle and pop one bit per live cycle
   always @(negedge clk) begin
      chk("x_valid", x_valid, reset && (nwords > 0) && enable);
      chk("in_ready", in_ready, reset && !flush && (nwords < 2));
      chk("busy", busy, nwords > 0);
      if (x_valid) begin
         if (expq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL extra_bit: got x_valid=1 expected no pending bits at %0t", $time);
         end else begin
            automatic ent_t t = expq.pop_front();
            chk("x", x, t.b);
            chk("frame_start", frame_start, t.s);
            chk("frame_end", frame_end, t.e);
         end
      end else begin
         chk("frame_start_idle", frame_start, 1'b0);
         chk("frame_end_idle", frame_end, 1'b0);
         if (nwords == 0) chk("x_idle", x, 1'b0);
      end
   end

   // Hold inputs for one clock edge; report x_valid as seen in that cycle
   task automatic step(input logic v, input logic [W-1:0] d, input logic e,
                       input logic f, output logic xv);
      in_valid = v;
      in_data  = d;
      enable   = e;
      flush    = f;
      #1 xv = x_valid;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic xv;
      int   cnt, first, last;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      enable   = 1'b0;
      flush    = 1'b0;

      // Reset state
      #12;
      chk("rst_x", x, 1'b0);
      chk("rst_x_valid", x_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0, xv);

      // Single word B4
      step(1'b1, 8'hB4, 1'b1, 1'b0, xv);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, xv);

      // Back-to-back B4 then 5A: 16 contiguous live cycles
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 20; i++) begin
         if (i == 0)      step(1'b1, 8'hB4, 1'b1, 1'b0, xv);
         else if (i == 1) step(1'b1, 8'h5A, 1'b1, 1'b0, xv);
         else             step(1'b0, '0, 1'b1, 1'b0, xv);
         if (xv) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      checks++;
      if (cnt != 16 || (last - first + 1) != 16) begin
         errors++;
         $display("FAIL b2b_contiguous: got %0d bits over span %0d expected 16 over 16", cnt, last - first + 1);
      end

      // Stall for 3 cycles while bit 3 of B4 is on x
      step(1'b1, 8'hB4, 1'b1, 1'b0, xv);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, xv);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b0, 1'b0, xv);
         chk("stall_x_valid", xv, 1'b0);
      end
      chk("stall_x", x, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, xv);

      // Flush at bit 5 of B4 with 5A held
      step(1'b1, 8'hB4, 1'b1, 1'b0, xv);
      step(1'b1, 8'h5A, 1'b1, 1'b0, xv);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, xv);
      step(1'b0, '0, 1'b1, 1'b1, xv);
      in_valid = 1'b0; enable = 1'b1; flush = 1'b0;
      #1;
      chk("flush_x_valid", x_valid, 1'b0);
      chk("flush_x", x, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      chk("flush_busy", busy, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, xv);

      // Async reset between edges while bit 2 is on x
      step(1'b1, 8'hB4, 1'b1, 1'b0, xv);
      step(1'b1, 8'h5A, 1'b1, 1'b0, xv);
      step(1'b0, '0, 1'b1, 1'b0, xv);
      #2 reset = 1'b0;
      #1;
      chk("arst_x_valid", x_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b1, 8'h0F, 1'b1, 1'b0, xv);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, xv);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, W'($urandom),
              ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, xv);
      end

      // Drain with a bounded budget
      for (int i = 0; i < 40 && nwords > 0; i++) step(1'b0, '0, 1'b1, 1'b0, xv);
      step(1'b0, '0, 1'b1, 1'b0, xv);
      checks++;
      if (nwords != 0 || expq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d words / %0d bits pending expected 0", nwords, expq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
